// File: rtl/audio_pkg.sv
// Shared types and constants for the PDM audio capture path.
// Latency: n/a. Backpressure: n/a.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam int CLK_HZ   = 100_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/pdm_decimator.sv
// Generates mic_clk, synchronises mic_data, and ones-counts DECIM bits per sample.
// Latency: sample_valid one cycle after the bit strobe that completes a window.
// Backpressure: none; the sample is valid for exactly one cycle.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int MIC_CLK_DIV = 50,
    parameter int DECIM       = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic                mic_data,
    output logic                mic_clk,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample
);

    localparam int DIV_W = (MIC_CLK_DIV > 1) ? $clog2(MIC_CLK_DIV) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic                mic_meta;
    logic                mic_sync;
    logic [SAMPLE_W-1:0] bit_cnt;
    logic [SAMPLE_W-1:0] acc;
    logic                div_tc;
    logic                bit_strobe;
    logic [SAMPLE_W-1:0] acc_next;

    assign div_tc     = (div_cnt == DIV_W'(MIC_CLK_DIV - 1));
    // Strobe on the cycle mic_clk is about to rise.
    assign bit_strobe = div_tc && !mic_clk;
    assign acc_next   = acc + SAMPLE_W'(mic_sync);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt      <= '0;
            mic_clk      <= 1'b0;
            mic_meta     <= 1'b0;
            mic_sync     <= 1'b0;
            bit_cnt      <= '0;
            acc          <= '0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            mic_meta     <= mic_data;
            mic_sync     <= mic_meta;
            div_cnt      <= div_tc ? '0 : div_cnt + DIV_W'(1);
            sample_valid <= 1'b0;
            if (div_tc) begin
                mic_clk <= ~mic_clk;
            end
            if (clear) begin
                bit_cnt <= '0;
                acc     <= '0;
            end else if (enable && bit_strobe) begin
                if (bit_cnt == SAMPLE_W'(DECIM - 1)) begin
                    sample       <= acc_next;
                    sample_valid <= 1'b1;
                    bit_cnt      <= '0;
                    acc          <= '0;
                end else begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + SAMPLE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pdm_audio_recorder.sv
// Records decimated PDM samples into a sample RAM from address 0 until stop or full.
// Latency: wr_en one cycle after the bit strobe closing each window.
// Backpressure: none; the RAM must accept every write strobe.
module pdm_audio_recorder
    import audio_pkg::*;
#(
    parameter int MIC_CLK_DIV = 50,
    parameter int DECIM       = 255,
    parameter int ADDR_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                mic_data,
    output logic                mic_clk,
    output logic                mic_lrsel,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     sample_count
);

    state_t              state;
    state_t              next_state;
    logic                clear;
    logic                last_addr;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;

    pdm_decimator #(
        .MIC_CLK_DIV(MIC_CLK_DIV),
        .DECIM      (DECIM)
    ) u_decim (
        .clk         (clk),
        .reset       (reset),
        .enable      (busy),
        .clear       (clear),
        .mic_data    (mic_data),
        .mic_clk     (mic_clk),
        .sample_valid(sample_valid),
        .sample      (sample)
    );

    assign mic_lrsel = 1'b0;
    assign busy      = (state == RECORD);
    assign done      = (state == DONE);
    assign clear     = start && (state != RECORD);
    assign last_addr = (wr_addr == {ADDR_W{1'b1}});
    // Gating with reset keeps a window completing in the reset cycle from writing.
    assign wr_en     = sample_valid && busy && !reset;
    assign wr_data   = sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = RECORD;
                end
            end
            RECORD: begin
                if (stop || (wr_en && last_addr)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr      <= '0;
            sample_count <= '0;
        end else if (clear) begin
            wr_addr      <= '0;
            sample_count <= '0;
        end else if (wr_en) begin
            sample_count <= sample_count + (ADDR_W + 1)'(1);
            if (!last_addr) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

endmodule
